// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed 7-segment driver with hex capture; defining SEG_BCD_EN
// replaces hex capture with a sequential double-dabble binary-to-decimal conversion.
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int unsigned PRESC_W = 20;
  localparam int unsigned NDIG    = 8;
  localparam int unsigned BCD_W   = 40;

  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0]    r_presc;
  logic [2:0]            r_idx;
  logic [NDIG-1:0][3:0]  r_digits;
  logic                  r_dash;
  logic [7:0]            r_seg;
  logic [7:0]            r_an;

  logic                  w_wrap;
  logic [2:0]            w_idx_nxt;
  logic                  w_upd;
  logic [31:0]           w_new_digits;
  logic                  w_new_dash;
  logic [NDIG-1:0][3:0]  w_digits_nxt;
  logic                  w_dash_nxt;
  logic [7:0]            w_seg_nxt;
  logic [7:0]            w_an_nxt;

`ifdef SEG_BCD_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                  r_state;
  logic [31:0]             r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [4:0]              r_cnt;
  logic                    r_busy;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W+32-1:0]     w_shift;

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble step: add-3 correction, then shift the next binary bit in
  always_comb begin
    w_bcd_adj = dd_adjust(r_bcd);
    w_shift   = {w_bcd_adj, r_bin} << 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin   <= data_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_shift[BCD_W+32-1:32];
          r_bin <= w_shift[31:0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Results above eight decimal digits cannot be shown, so the whole display dashes
  always_comb begin
    w_upd        = (r_state == S_DONE);
    w_new_digits = r_bcd[31:0];
    w_new_dash   = |r_bcd[BCD_W-1:32];
  end

  assign busy = r_busy;
`else
  always_comb begin
    w_upd        = load;
    w_new_digits = data_in;
    w_new_dash   = 1'b0;
  end

  assign busy = 1'b0;
`endif

  // seg/an are registered from next-state values so they always match index and digits
  always_comb begin
    w_wrap       = (r_presc == PRESC_W'(SCAN_DIV - 1));
    w_idx_nxt    = w_wrap ? r_idx + 3'd1 : r_idx;
    w_digits_nxt = r_digits;
    w_dash_nxt   = r_dash;
    if (w_upd) begin
      w_digits_nxt = w_new_digits;
      w_dash_nxt   = w_new_dash;
    end
    w_seg_nxt = w_dash_nxt ? 8'hBF : hex7(w_digits_nxt[w_idx_nxt]);
    w_an_nxt  = ~(8'h01 << w_idx_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_digits <= '0;
      r_dash   <= 1'b0;
      r_seg    <= 8'hC0;
      r_an     <= 8'hFE;
    end else begin
      r_presc  <= w_wrap ? '0 : r_presc + PRESC_W'(1);
      r_idx    <= w_idx_nxt;
      r_digits <= w_digits_nxt;
      r_dash   <= w_dash_nxt;
      r_seg    <= w_seg_nxt;
      r_an     <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
